// File: rtl/int_div_iterative.sv
// int_div_iterative: 32-bit signed divider using restoring shift-subtract, one quotient bit per cycle.
module int_div_iterative (
  input  logic        clk,
  input  logic        reset,
  input  logic        istream_val,
  output logic        istream_rdy,
  input  logic [63:0] istream_msg,
  output logic        ostream_val,
  input  logic        ostream_rdy,
  output logic [63:0] ostream_msg
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [5:0] cnt;
  logic [63:0] rq, sh, step;
  logic [31:0] a_in, b_in, b_mag, diff, q_fin, r_fin;
  logic neg_q, neg_r, div0, accept;
  assign a_in = istream_msg[63:32];
  assign b_in = istream_msg[31:0];
  assign accept = state == IDLE && istream_val;
  always_comb begin
    sh = rq << 1;
    diff = sh[63:32] - b_mag;
    step = sh[63:32] >= b_mag ? {diff, sh[31:1], 1'b1} : sh;
    q_fin = div0 ? '1 : (neg_q ? -step[31:0] : step[31:0]);
    r_fin = neg_r ? -step[63:32] : step[63:32];
    state_nx = accept ? CALC
             : (state == CALC && cnt == 6'd31) ? DONE
             : (state == DONE && ostream_rdy) ? IDLE : state;
    istream_rdy = state == IDLE;
    ostream_val = state == DONE;
  end
  // Magnitudes are taken as unsigned 32-bit values, so 32'h80000000 needs no special handling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rq <= '0;
      b_mag <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0 <= 1'b0;
      ostream_msg <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= '0;
        rq <= {32'd0, a_in[31] ? -a_in : a_in};
        b_mag <= b_in[31] ? -b_in : b_in;
        neg_q <= a_in[31] ^ b_in[31];
        neg_r <= a_in[31];
        div0 <= b_in == 32'd0;
      end else if (state == CALC) begin
        cnt <= cnt + 6'd1;
        rq <= step;
        if (cnt == 6'd31) ostream_msg <= {r_fin, q_fin};
      end
    end
  end
`ifndef SYNTHESIS
  task automatic display_trace();
    $display("[%0t] state=%s cnt=%0d rq=%h b_mag=%h msg=%h", $time, state.name(), cnt, rq, b_mag, ostream_msg);
  endtask
`endif
endmodule

// File: tb/tb_int_div_iterative.sv
// tb_int_div_iterative: directed and random checks of int_div_iterative with a result scoreboard.
module tb_int_div_iterative;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic istream_val = 1'b0;
  logic istream_rdy;
  logic [63:0] istream_msg = '0;
  logic ostream_val;
  logic ostream_rdy = 1'b1;
  logic [63:0] ostream_msg;
  logic [63:0] sq[$];
  int n_checks = 0;
  int n_fails = 0;
  int_div_iterative dut (
    .clk(clk), .reset(reset),
    .istream_val(istream_val), .istream_rdy(istream_rdy), .istream_msg(istream_msg),
    .ostream_val(ostream_val), .ostream_rdy(ostream_rdy), .ostream_msg(ostream_msg)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (ostream_val && ostream_rdy) dut.display_trace();
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    @(negedge clk);
    while (!istream_rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("accept_rdy", 64'(istream_rdy), 64'd1);
    istream_val = 1'b1;
    istream_msg = {a, b};
    sq.push_back(ref_div(a, b));
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    istream_msg = {$urandom, $urandom};
  endtask
  task automatic recv(input int hold);
    int n = 0;
    logic [63:0] exp, held;
    while (!ostream_val && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'd32);
    exp = sq.pop_front();
    check("result", ostream_msg, exp);
    held = ostream_msg;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("bp_val", 64'(ostream_val), 64'd1);
      check("bp_msg", ostream_msg, held);
      check("bp_irdy", 64'(istream_rdy), 64'd0);
    end
    ostream_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("idle_irdy", 64'(istream_rdy), 64'd1);
    check("idle_oval", 64'(ostream_val), 64'd0);
  endtask
  initial begin
    logic [31:0] a, b;
    #3;
    check("rst_irdy", 64'(istream_rdy), 64'd1);
    check("rst_oval", 64'(ostream_val), 64'd0);
    check("rst_msg", ostream_msg, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    send(32'd100, 32'd7); recv(0);
    check("basic_exp", ref_div(32'd100, 32'd7), {32'd2, 32'd14});
    send(-32'sd100, 32'd7); recv(0);
    send(32'd100, -32'sd7); recv(0);
    send(-32'sd100, -32'sd7); recv(0);
    send(32'd5, 32'd0); recv(0);
    send(32'h80000000, 32'hFFFFFFFF); recv(0);
    send(32'd0, 32'd9); recv(0);
    send(-32'sd7, 32'd0); recv(0);
    ostream_rdy = 1'b0;
    send(32'd1000, 32'd33); recv(10);
    ostream_rdy = 1'b1;
    send(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_irdy", 64'(istream_rdy), 64'd1);
    check("mid_rst_oval", 64'(ostream_val), 64'd0);
    check("mid_rst_msg", ostream_msg, 64'd0);
    sq.delete();
    @(negedge clk);
    reset = 1'b0;
    send(32'd12, 32'd5); recv(0);
    check("post_rst_exp", ref_div(32'd12, 32'd5), {32'd2, 32'd2});
    for (int i = 0; i < 100; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = b >> $urandom_range(31, 16);
      if (b == 32'd0) b = 32'd1;
      send(a, b);
      recv(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/int_div_iterative.md
INT_DIV_ITERATIVE -- requirements
Module: int_div_iterative

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit operands.
REQ-002 The port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 The port reset, input, 1 bit, SHALL be an asynchronous active-high reset.
REQ-004 The port istream_val, input, 1 bit, SHALL indicate a valid request.
REQ-005 The port istream_rdy, output, 1 bit, SHALL indicate that the block can accept a request.
REQ-006 The port istream_msg, input, 64 bits, SHALL carry the signed dividend in [63:32] and the signed divisor in [31:0].
REQ-007 The port ostream_val, output, 1 bit, SHALL indicate a valid result.
REQ-008 The port ostream_rdy, input, 1 bit, SHALL indicate that the consumer accepts the result.
REQ-009 The port ostream_msg, output, 64 bits, SHALL carry the signed remainder in [63:32] and the signed quotient in [31:0].

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, CALC and DONE.
REQ-011 In IDLE the block SHALL drive istream_rdy=1 and ostream_val=0; in CALC and DONE it SHALL drive istream_rdy=0.
REQ-012 A request SHALL be accepted on a rising edge with state=IDLE and istream_val=1; the FSM then moves to CALC, captures both operands and clears the iteration counter.
REQ-013 CALC SHALL perform one restoring shift-subtract step per cycle on operand magnitudes, using a 64-bit remainder/quotient register and a 6-bit counter.
REQ-014 After exactly 32 CALC edges the FSM SHALL move to DONE.
REQ-015 ostream_val SHALL be 1 in DONE only, starting exactly 32 cycles after the accept edge, independent of operand values.
REQ-016 Quotient sign SHALL be dividend sign XOR divisor sign; remainder sign SHALL equal dividend sign, with truncation toward zero.
REQ-017 For divisor=0 the block SHALL return quotient=32'hFFFFFFFF and remainder=dividend.
REQ-018 For dividend=32'h80000000 and divisor=32'hFFFFFFFF the block SHALL return quotient=32'h80000000 and remainder=0.
REQ-019 ostream_msg SHALL hold its value while ostream_val=1 and ostream_rdy=0; the result is never dropped or altered.
REQ-020 On a rising edge in DONE with ostream_rdy=1 the FSM SHALL return to IDLE, so istream_rdy=1 in the next cycle; back-to-back gap is one cycle.
REQ-021 istream_val and istream_msg SHALL be ignored outside IDLE, and changes after accept SHALL NOT affect the result.
REQ-022 ostream_rdy SHALL be ignored outside DONE.
REQ-023 The block SHALL provide a display_trace task printing state, operands and the result, for use by the bench at the negative clock edge.

Reset
REQ-024 Asserting reset SHALL immediately force state=IDLE, istream_rdy=1, ostream_val=0, ostream_msg=0 and counter=0, with no clock edge required.
REQ-025 Reset asserted during CALC or DONE SHALL abort the operation and discard its result; the first request after reset deassertion SHALL complete normally.

Verification
REQ-026 The bench SHALL check a basic case: msg a=100, b=7, ostream_rdy=1 -> quotient 14, remainder 2, ostream_val high exactly 32 cycles after accept.
REQ-027 The bench SHALL check sign cases: (-100,7) -> q=-14, r=-2; (100,-7) -> q=-14, r=2; (-100,-7) -> q=14, r=-2.
REQ-028 The bench SHALL check corner cases: (5,0) -> q=32'hFFFFFFFF, r=5; (32'h80000000, 32'hFFFFFFFF) -> q=32'h80000000, r=0; (0,9) -> q=0, r=0.
REQ-029 The bench SHALL check backpressure: hold ostream_rdy=0 for 10 cycles in DONE -> ostream_val and ostream_msg stable and istream_rdy=0; release -> IDLE next cycle.
REQ-030 The bench SHALL check reset mid-operation: assert reset 10 cycles into CALC -> outputs at reset values immediately; then (12,5) -> q=2, r=2.
REQ-031 The bench SHALL run 100 random signed pairs, with zero divisors excluded, and check each result against the reference operators / and %.
